// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-enabled h/v counters, sync/blank, line/frame strobes, frame count.
// Define VGA_TIMING_OUT_PIPE_EN to delay hsync/vsync/display_on by one extra register stage.
module vga_timing_gen #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       line_end,
  output logic       frame_end,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  // 11-bit bounds so a 1024-pixel visible region still compares correctly
  localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
  localparam logic [10:0] H_SS     = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] H_SE     = 11'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
  localparam logic [10:0] V_SS     = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] V_SE     = 11'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic        H_ACTIVE = 1'(H_SYNC_POL);
  localparam logic        V_ACTIVE = 1'(V_SYNC_POL);

  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       display_on_q, display_on_d;
  logic       h_wrap, v_wrap;
  logic [10:0] h_ext, v_ext;

  assign h_wrap = (hpos_q == H_LAST);
  assign v_wrap = (vpos_q == V_LAST);

  always_comb begin
    hpos_d        = hpos_q;
    vpos_d        = vpos_q;
    frame_count_d = frame_count_q;
    if (pix_en) begin
      if (h_wrap) begin
        hpos_d = '0;
        if (v_wrap) begin
          vpos_d        = '0;
          frame_count_d = frame_count_q + 8'd1;
        end else begin
          vpos_d = vpos_q + 10'd1;
        end
      end else begin
        hpos_d = hpos_q + 10'd1;
      end
    end
  end

  // Decode from the next-state counters so the registered flags line up with hpos/vpos.
  always_comb begin
    h_ext        = {1'b0, hpos_d};
    v_ext        = {1'b0, vpos_d};
    hsync_d      = (h_ext >= H_SS && h_ext <= H_SE) ? H_ACTIVE : ~H_ACTIVE;
    vsync_d      = (v_ext >= V_SS && v_ext <= V_SE) ? V_ACTIVE : ~V_ACTIVE;
    display_on_d = (h_ext < H_VIS) && (v_ext < V_VIS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hpos_q        <= '0;
      vpos_q        <= '0;
      frame_count_q <= '0;
      hsync_q       <= ~H_ACTIVE;
      vsync_q       <= ~V_ACTIVE;
      display_on_q  <= 1'b1;
    end else begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      frame_count_q <= frame_count_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      display_on_q  <= display_on_d;
    end
  end

`ifdef VGA_TIMING_OUT_PIPE_EN
  logic hsync_p_q, vsync_p_q, display_on_p_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_p_q      <= ~H_ACTIVE;
      vsync_p_q      <= ~V_ACTIVE;
      display_on_p_q <= 1'b1;
    end else begin
      hsync_p_q      <= hsync_q;
      vsync_p_q      <= vsync_q;
      display_on_p_q <= display_on_q;
    end
  end

  assign hsync      = hsync_p_q;
  assign vsync      = vsync_p_q;
  assign display_on = display_on_p_q;
`else
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign display_on = display_on_q;
`endif

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign frame_count = frame_count_q;
  assign line_end    = pix_en & h_wrap;
  assign frame_end   = pix_en & h_wrap & v_wrap;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA raster timing for the Game-of-Life display path.
- Sits directly upstream of the top-level pixel logic. Supplies hsync, vsync, display_on and hpos/vpos, which drive frame masking, cell indexing and the simulation trigger.
- Adds a pixel-enable input, line/frame end strobes and a frame counter so downstream logic can pace simulation updates without its own cycle timer.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_SYNC_POL, 0, hsync active level (0 = active low)
- V_SYNC_POL, 0, vsync active level (0 = active low)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- pix_en  input  1  pixel-advance enable; counters step only when high
- hsync  output  1  horizontal sync, polarity per H_SYNC_POL
- vsync  output  1  vertical sync, polarity per V_SYNC_POL
- display_on  output  1  high when hpos < H_DISPLAY and vpos < V_DISPLAY
- hpos  output  10  current pixel column, 0..H_TOTAL-1
- vpos  output  10  current line, 0..V_TOTAL-1
- line_end  output  1  one-cycle strobe on the advancing cycle at hpos = H_TOTAL-1
- frame_end  output  1  one-cycle strobe on the advancing cycle at hpos = H_TOTAL-1, vpos = V_TOTAL-1
- frame_count  output  8  frames completed, modulo 256

Behaviour:
- Totals: H_TOTAL = sum of H params = 800; V_TOTAL = 525. Both must be ≤ 1024; a synthesis-time check errors otherwise.
- Reset, synchronous, priority over pix_en: hpos=0, vpos=0, frame_count=0, display_on=1, hsync=~H_SYNC_POL, vsync=~V_SYNC_POL. Takes effect on the clock edge in any state, including mid-line or mid-sync; no partial-frame carry-over.
- Horizontal counter advance (clk edge with pix_en=1):
  - hpos = H_TOTAL-1 → hpos wraps to 0.
  - Otherwise hpos+1.
- Vertical counter advance:
  - vpos changes only on an hpos wrap.
  - vpos = V_TOTAL-1 → vpos wraps to 0 and frame_count increments (255 → 0 wraps silently).
  - Otherwise vpos+1.
- pix_en=0: all registers hold; strobes are 0.
- hsync, vsync and display_on are registered from the next-state counter values. They are therefore always consistent with the hpos/vpos presented in the same cycle (zero relative latency).
- hsync active for hpos in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = 656..751.
- vsync active for vpos in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] = 490..491, across the full line width.
- line_end and frame_end are combinational from the current counters AND pix_en.
  - frame_end implies line_end.
  - Both are high in the same cycle whose edge performs the wrap.
- Simultaneous reset and pix_en: reset wins; strobes are still a function of the pre-reset counters for that cycle.

Optional Feature:
- VGA_TIMING_OUT_PIPE_EN defined: hsync, vsync and display_on gain one extra register stage and lag hpos/vpos by exactly one clk cycle. This matches a downstream registered RGB stage. During reset the pipe registers also take the reset values above.
- Undefined: zero relative latency, as specified in Behaviour.
- hpos, vpos, strobes and frame_count are unaffected either way.

Test Plan:
- Reset behaviour: assert reset 3 cycles at arbitrary position → next cycle hpos=0, vpos=0, frame_count=0, display_on=1, hsync=1, vsync=1.
- Horizontal timing: pix_en=1 constant over one line →
  - hsync low for exactly 96 cycles, first at hpos=656, last at 751;
  - display_on low for hpos 640..799;
  - line_end high only at hpos=799.
- Vertical timing: one full frame →
  - vsync low exactly 1600 cycles, vpos 490..491;
  - frame_end single pulse at (799,524);
  - frame_count 0→1;
  - total 420000 cycles per frame.
- pix_en gating: pix_en toggled 1,0,1,0 → hpos advances every other cycle; frame length 840000 cycles; no strobes while pix_en=0.
- Frame count wrap and mid-frame reset: run 256 frames → frame_count returns to 0. Then reset at vpos=490 while vsync active → vsync deasserts next cycle, counters at 0.
- Optional pipe: with VGA_TIMING_OUT_PIPE_EN, hsync first goes low one cycle after hpos=656 and display_on falls one cycle after hpos=640; without the macro both align with hpos.
